// File: rtl/adder_result_checker.sv
// adder_result_checker: self-check stage that sits behind a WIDTH-bit adder.
// Each accepted operand pair has its expected sum delayed by LATENCY cycles.
// The delayed sum is compared with the observed result. Pass and fail counts
// saturate, and the first failing vector is captured.
// Optional macro ADDER_CHK_DISPLAY_EN: when defined, mismatches and the final
// statistics are printed during simulation. When undefined, no system tasks
// are compiled and the port behaviour is the same.
module adder_result_checker #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_c
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_fail_seen;
  logic [WIDTH-1:0] r_first_a;
  logic [WIDTH-1:0] r_first_b;
  logic [WIDTH-1:0] r_first_c;

  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic             w_tail_valid;
  logic [WIDTH-1:0] w_tail_a;
  logic [WIDTH-1:0] w_tail_b;
  logic [WIDTH-1:0] w_tail_exp;
  logic             w_rest_valid;
  logic             w_compare;
  logic             w_match;

  // A start pulse takes priority over accepting a vector in the same cycle.
  assign w_accept  = (r_state == S_RUN) && in_valid && !start;
  // The carry out is dropped, so the sum wraps modulo 2^WIDTH.
  assign w_sum     = a + b;
  // A start pulse discards any compare that falls in the same cycle.
  assign w_compare = w_tail_valid && !start;
  assign w_match   = (w_tail_exp == c);

  generate
    if (LATENCY == 0) begin : g_nopipe
      // The compare happens in the acceptance cycle, so no storage is needed.
      assign w_tail_valid = w_accept;
      assign w_tail_a     = a;
      assign w_tail_b     = b;
      assign w_tail_exp   = w_sum;
      assign w_rest_valid = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_vld;
      logic [WIDTH-1:0]   r_pa   [LATENCY];
      logic [WIDTH-1:0]   r_pb   [LATENCY];
      logic [WIDTH-1:0]   r_pexp [LATENCY];

      // Shift register for in-flight vectors. It moves every cycle and is
      // emptied by start.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          for (int i = 0; i < LATENCY; i++) begin
            r_pa[i]   <= '0;
            r_pb[i]   <= '0;
            r_pexp[i] <= '0;
          end
        end else if (start) begin
          r_vld <= '0;
        end else begin
          r_vld[0]  <= w_accept;
          r_pa[0]   <= a;
          r_pb[0]   <= b;
          r_pexp[0] <= w_sum;
          for (int i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_pa[i]   <= r_pa[i-1];
            r_pb[i]   <= r_pb[i-1];
            r_pexp[i] <= r_pexp[i-1];
          end
        end
      end

      assign w_tail_valid = r_vld[LATENCY-1];
      assign w_tail_a     = r_pa[LATENCY-1];
      assign w_tail_b     = r_pb[LATENCY-1];
      assign w_tail_exp   = r_pexp[LATENCY-1];

      // These are the stages that still hold a vector after the next shift.
      // When none of them is valid, DRAIN can end on this edge.
      if (LATENCY > 1) begin : g_rest
        assign w_rest_valid = |r_vld[LATENCY-2:0];
      end else begin : g_norest
        assign w_rest_valid = 1'b0;
      end
    end
  endgenerate

  // Control FSM with registered busy/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (start) begin
            r_state <= S_RUN;
          end else if (stop) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (start) begin
            r_state <= S_RUN;
          end else if (!w_rest_valid) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics and first-failure capture. Both update on the edge
  // after the compare cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_c   <= '0;
    end else if (start) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_fail_seen <= 1'b0;
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_c   <= '0;
    end else if (w_compare) begin
      if (w_match) begin
        if (r_pass_cnt != {CNT_W{1'b1}}) begin
          r_pass_cnt <= r_pass_cnt + CNT_W'(1);
        end
      end else begin
        if (r_fail_cnt != {CNT_W{1'b1}}) begin
          r_fail_cnt <= r_fail_cnt + CNT_W'(1);
        end
        if (!r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_first_a   <= w_tail_a;
          r_first_b   <= w_tail_b;
          r_first_c   <= c;
        end
      end
    end
  end

`ifdef ADDER_CHK_DISPLAY_EN
  logic r_done_q;

  // Simulation trace: report each mismatch and the totals when DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= r_done;
      if (w_compare && !w_match) begin
        $display("%0t: MISMATCH a=%h b=%h exp=%h got=%h",
                 $time, w_tail_a, w_tail_b, w_tail_exp, c);
      end
      if (r_done && !r_done_q) begin
        $display("%0t: CHECK pass=%0d fail=%0d", $time, r_pass_cnt, r_fail_cnt);
      end
    end
  end
`else
  // No simulation trace in the synthesizable build.
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass_cnt  = r_pass_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign fail_seen = r_fail_seen;
  assign first_a   = r_first_a;
  assign first_b   = r_first_b;
  assign first_c   = r_first_c;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed testbench for adder_result_checker. The main instance uses the
// default parameters (LATENCY=1, CNT_W=16). A second instance uses CNT_W=4 to
// exercise counter saturation.
module tb_adder_result_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;

  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        fail_seen;
  logic [15:0] first_a;
  logic [15:0] first_b;
  logic [15:0] first_c;

  logic        s_busy;
  logic        s_done;
  logic [3:0]  s_pass_cnt;
  logic [3:0]  s_fail_cnt;
  logic        s_fail_seen;
  logic [15:0] s_first_a;
  logic [15:0] s_first_b;
  logic [15:0] s_first_c;

  int n_vec;
  int n_miss;

  adder_result_checker #(.WIDTH(16), .LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
    .first_a(first_a), .first_b(first_b), .first_c(first_c)
  );

  adder_result_checker #(.WIDTH(16), .LATENCY(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .busy(s_busy), .done(s_done),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .fail_seen(s_fail_seen),
    .first_a(s_first_a), .first_b(s_first_b), .first_c(s_first_c)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs. Returns 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ic, input logic st, input logic sp);
    in_valid = v;
    a        = ia;
    b        = ib;
    c        = ic;
    start    = st;
    stop     = sp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    in_valid = 1'b0;
    a        = 16'd0;
    b        = 16'd0;
    c        = 16'd0;

    // Reset: in_valid and stop toggle while rst is held; nothing may move.
    drive(1'b1, 16'd3, 16'd4, 16'd9, 1'b0, 1'b0);
    drive(1'b0, 16'd3, 16'd4, 16'd9, 1'b0, 1'b1);
    drive(1'b1, 16'd5, 16'd6, 16'd1, 1'b0, 1'b0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {16'd0, pass_cnt}, 32'd0);
    check("rst_fail", {16'd0, fail_cnt}, 32'd0);
    check("rst_seen", {31'd0, fail_seen}, 32'd0);
    check("rst_first_a", {16'd0, first_a}, 32'd0);
    rst = 1'b0;
    // IDLE ignores in_valid and stop.
    drive(1'b1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd7, 1'b0, 1'b0);
    check("idle_fail", {16'd0, fail_cnt}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic pass: expected sums 30, 400 and 1.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("run_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 16'd10, 16'd20, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd100, 16'd300, 16'd30, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 16'd0, 16'd400, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 16'd1, 1'b0, 1'b1);
    check("drain_done", {31'd0, done}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_busy", {31'd0, busy}, 32'd0);
    check("basic_pass", {16'd0, pass_cnt}, 32'd3);
    check("basic_fail", {16'd0, fail_cnt}, 32'd0);
    check("basic_seen", {31'd0, fail_seen}, 32'd0);

    // In DONE, in_valid and stop are ignored.
    drive(1'b1, 16'd9, 16'd9, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("done_ign_pass", {16'd0, pass_cnt}, 32'd3);
    check("done_ign_fail", {16'd0, fail_cnt}, 32'd0);
    check("done_hold", {31'd0, done}, 32'd1);

    // Wrap-around: FFFF + 0002 gives 0001 with the carry dropped.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_pass", {16'd0, pass_cnt}, 32'd0);
    drive(1'b1, 16'hFFFF, 16'h0002, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 16'h0001, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("wrap_pass", {16'd0, pass_cnt}, 32'd1);
    check("wrap_fail", {16'd0, fail_cnt}, 32'd0);

    // Mismatch capture: (5,5)->10 passes, (7,8)->16 fails, (1,1)->3 fails.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b1, 16'd5, 16'd5, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd7, 16'd8, 16'd10, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 16'd1, 16'd16, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 16'd3, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("mm_pass", {16'd0, pass_cnt}, 32'd1);
    check("mm_fail", {16'd0, fail_cnt}, 32'd2);
    check("mm_seen", {31'd0, fail_seen}, 32'd1);
    check("mm_first_a", {16'd0, first_a}, 32'd7);
    check("mm_first_b", {16'd0, first_b}, 32'd8);
    check("mm_first_c", {16'd0, first_c}, 32'd16);

    // stop together with in_valid: (2,3) is still accepted and compared.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("start_clr_seen", {31'd0, fail_seen}, 32'd0);
    check("start_clr_first", {16'd0, first_c}, 32'd0);
    drive(1'b1, 16'd2, 16'd3, 16'd0, 1'b0, 1'b1);
    check("sv_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 16'd0, 16'd0, 16'd5, 1'b0, 1'b0);
    check("sv_done", {31'd0, done}, 32'd1);
    check("sv_pass", {16'd0, pass_cnt}, 32'd1);
    check("sv_fail", {16'd0, fail_cnt}, 32'd0);

    // Mid-run start: the passing compare of (1,1) is discarded and a stale
    // mismatching vector in flight is flushed.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    drive(1'b1, 16'd4, 16'd4, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 16'd1, 16'd8, 1'b0, 1'b0);
    check("mid_pre_pass", {16'd0, pass_cnt}, 32'd1);
    drive(1'b0, 16'd0, 16'd0, 16'd2, 1'b1, 1'b0);
    check("mid_pass", {16'd0, pass_cnt}, 32'd0);
    check("mid_fail", {16'd0, fail_cnt}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 16'd0, 16'd0, 16'd99, 1'b0, 1'b0);
    check("mid_flush", {16'd0, fail_cnt}, 32'd0);
    drive(1'b1, 16'd1, 16'd2, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 16'd3, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("mid_after_pass", {16'd0, pass_cnt}, 32'd1);
    check("mid_after_done", {31'd0, done}, 32'd1);

    // Saturation: 20 passing vectors (i,i) with expected sum 2*i.
    drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 16'(i), 16'(i), 16'(2 * (i - 1)), 1'b0, 1'b0);
    end
    drive(1'b0, 16'd0, 16'd0, 16'd40, 1'b0, 1'b0);
    check("sat_main_pass", {16'd0, pass_cnt}, 32'd20);
    check("sat4_pass", {28'd0, s_pass_cnt}, 32'd15);
    check("sat4_fail", {28'd0, s_fail_cnt}, 32'd0);

    // Reset mid-RUN with one vector in flight: everything returns to zero.
    drive(1'b1, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_pass", {16'd0, pass_cnt}, 32'd0);
    check("mrst_sat_pass", {28'd0, s_pass_cnt}, 32'd0);
    drive(1'b1, 16'd0, 16'd0, 16'd6, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 16'd2, 16'd2, 16'd6, 1'b0, 1'b0);
    drive(1'b1, 16'd2, 16'd2, 16'd4, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 16'd4, 1'b0, 1'b0);
    check("post_rst_pass", {16'd0, pass_cnt}, 32'd0);
    check("post_rst_fail", {16'd0, fail_cnt}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
